// File: rtl/axil_wb_pkg.sv
// Constants and types shared by the AXI-lite to Wishbone read and write bridges.
// Both bridges use the same response encodings.
package axil_wb_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // RD_DRAIN marks every issued-but-unanswered read as failed after a bus error.
  typedef enum logic {
    RD_RUN   = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

  function automatic logic [1:0] axi_resp(input logic err);
    if (err) begin
      return AXI_RESP_SLVERR;
    end else begin
      return AXI_RESP_OKAY;
    end
  endfunction

endpackage

// File: rtl/wb_rsp_fifo.sv
// Response storage for the read bridge: synchronous write, asynchronous read.
// The owner keeps all pointer state, so this is a plain register file.
module wb_rsp_fifo #(
  parameter int LGFIFO = 3,
  parameter int WIDTH  = 33
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [LGFIFO-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [LGFIFO-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] mem_q [0:(1<<LGFIFO)-1];

  // Contents are deliberately not reset; validity is tracked by the owner's pointers.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/axil_rd2wbsp.sv
// AXI-lite read channel (AR/R) to pipelined Wishbone read master.
// In-order issue, up to 2^LGFIFO outstanding reads; bus errors become SLVERR.
module axil_rd2wbsp
  import axil_wb_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int LGFIFO           = 3,
  localparam int DW              = C_AXI_DATA_WIDTH,
  localparam int LSBS            = $clog2(C_AXI_DATA_WIDTH/8),
  localparam int AW              = C_AXI_ADDR_WIDTH - LSBS
) (
  input  logic                        i_clk,
  input  logic                        i_axi_reset_n,
  input  logic                        i_axi_arvalid,
  output logic                        o_axi_arready,
  input  logic [C_AXI_ADDR_WIDTH-1:0] i_axi_araddr,
  input  logic [2:0]                  i_axi_arprot,
  output logic                        o_axi_rvalid,
  input  logic                        i_axi_rready,
  output logic [DW-1:0]               o_axi_rdata,
  output logic [1:0]                  o_axi_rresp,
  output logic                        o_wb_cyc,
  output logic                        o_wb_stb,
  output logic [AW-1:0]               o_wb_addr,
  output logic [DW/8-1:0]             o_wb_sel,
  input  logic                        i_wb_ack,
  input  logic                        i_wb_stall,
  input  logic                        i_wb_err,
  input  logic [DW-1:0]               i_wb_data
);

  localparam int PW = LGFIFO + 1;
  localparam logic [PW-1:0] PTR_ONE = {{LGFIFO{1'b0}}, 1'b1};
  localparam logic [PW-1:0] DEPTH   = {1'b1, {LGFIFO{1'b0}}};

  rd_state_e     state_q, state_d;
  logic [PW-1:0] r_first_q, r_first_d;
  logic [PW-1:0] r_mid_q, r_mid_d;
  logic [PW-1:0] r_last_q, r_last_d;
  logic          stb_q, stb_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          err_state_s;
  logic          full_s;
  logic          cyc_s;
  logic          wb_err_s;
  logic          ar_accept_s;
  logic          rsp_we_s;
  logic          rsp_err_s;
  logic          r_hs_s;
  logic [DW:0]   rsp_rd_s;
  logic          unused_s;

  assign err_state_s = (state_q == RD_DRAIN);
  assign full_s      = ((r_first_q - r_last_q) == DEPTH);
  assign cyc_s       = (r_first_q != r_mid_q) && !err_state_s;
  assign wb_err_s    = cyc_s && i_wb_err;

  // arready never looks at arvalid, so it cannot form a combinational loop upstream.
  assign o_axi_arready = (!stb_q || !i_wb_stall) && !full_s && !err_state_s && !wb_err_s;
  assign ar_accept_s   = i_axi_arvalid && o_axi_arready;

  assign rsp_we_s  = (cyc_s && (i_wb_ack || i_wb_err)) || (err_state_s && (r_mid_q != r_first_q));
  assign rsp_err_s = err_state_s || i_wb_err;

  assign o_axi_rvalid = (r_mid_q != r_last_q);
  assign r_hs_s       = o_axi_rvalid && i_axi_rready;

  // Error drain FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_RUN: begin
        if (wb_err_s) begin
          state_d = RD_DRAIN;
        end else begin
          state_d = RD_RUN;
        end
      end
      RD_DRAIN: begin
        if (r_mid_q == r_first_q) begin
          state_d = RD_RUN;
        end else begin
          state_d = RD_DRAIN;
        end
      end
      default: state_d = RD_RUN;
    endcase
  end

  // Request side: issue pointer, strobe and address
  always_comb begin
    r_first_d = r_first_q;
    stb_d     = stb_q;
    addr_d    = addr_q;
    if (ar_accept_s) begin
      r_first_d = r_first_q + PTR_ONE;
      stb_d     = 1'b1;
      addr_d    = i_axi_araddr[C_AXI_ADDR_WIDTH-1:LSBS];
    end else if (!i_wb_stall || wb_err_s) begin
      stb_d = 1'b0;
    end else begin
      stb_d = stb_q;
    end
  end

  // Response side: bus-return and AXI-return pointers advance independently
  always_comb begin
    r_mid_d  = r_mid_q;
    r_last_d = r_last_q;
    if (rsp_we_s) begin
      r_mid_d = r_mid_q + PTR_ONE;
    end else begin
      r_mid_d = r_mid_q;
    end
    if (r_hs_s) begin
      r_last_d = r_last_q + PTR_ONE;
    end else begin
      r_last_d = r_last_q;
    end
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
    if (!i_axi_reset_n) begin
      state_q   <= RD_RUN;
      r_first_q <= {PW{1'b0}};
      r_mid_q   <= {PW{1'b0}};
      r_last_q  <= {PW{1'b0}};
      stb_q     <= 1'b0;
      addr_q    <= {AW{1'b0}};
    end else begin
      state_q   <= state_d;
      r_first_q <= r_first_d;
      r_mid_q   <= r_mid_d;
      r_last_q  <= r_last_d;
      stb_q     <= stb_d;
      addr_q    <= addr_d;
    end
  end

  wb_rsp_fifo #(
    .LGFIFO (LGFIFO),
    .WIDTH  (DW + 1)
  ) u_rsp_fifo (
    .i_clk   (i_clk),
    .i_we    (rsp_we_s),
    .i_waddr (r_mid_q[LGFIFO-1:0]),
    .i_wdata ({i_wb_data, rsp_err_s}),
    .i_raddr (r_last_q[LGFIFO-1:0]),
    .o_rdata (rsp_rd_s)
  );

  assign o_axi_rdata = rsp_rd_s[DW:1];
  assign o_axi_rresp = axi_resp(rsp_rd_s[0]);

  assign o_wb_cyc  = cyc_s;
  assign o_wb_stb  = stb_q;
  assign o_wb_addr = addr_q;
  assign o_wb_sel  = {(DW/8){1'b1}};

  // Protection bits and sub-word address bits carry no meaning on this bus.
  assign unused_s = ^{i_axi_arprot, i_axi_araddr};

endmodule

// File: tb/tb_axil_rd2wbsp.sv
// Directed self-checking bench for axil_rd2wbsp with a small Wishbone slave model.
// Expected read data is derived from the byte address the bench issued.
module tb_axil_rd2wbsp;

  logic        clk;
  logic        rst_n;
  logic        arvalid;
  logic        arready;
  logic [27:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        wb_cyc, wb_stb;
  logic [25:0] wb_addr;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_stall, wb_err;
  logic [31:0] wb_data;

  // manual (m_) and slave-model (s_) Wishbone drives, muxed by slv_en
  logic        m_ack, m_stall, m_err;
  logic [31:0] m_data;
  logic        s_ack, s_stall;
  logic [31:0] s_data;
  logic        slv_en, slv_stall_rnd;
  int          slv_maxdly;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp;
  int n_err;

  assign wb_ack   = slv_en ? s_ack   : m_ack;
  assign wb_stall = slv_en ? s_stall : m_stall;
  assign wb_err   = slv_en ? 1'b0    : m_err;
  assign wb_data  = slv_en ? s_data  : m_data;

  axil_rd2wbsp dut (
    .i_clk         (clk),
    .i_axi_reset_n (rst_n),
    .i_axi_arvalid (arvalid),
    .o_axi_arready (arready),
    .i_axi_araddr  (araddr),
    .i_axi_arprot  (3'b000),
    .o_axi_rvalid  (rvalid),
    .i_axi_rready  (rready),
    .o_axi_rdata   (rdata),
    .o_axi_rresp   (rresp),
    .o_wb_cyc      (wb_cyc),
    .o_wb_stb      (wb_stb),
    .o_wb_addr     (wb_addr),
    .o_wb_sel      (wb_sel),
    .i_wb_ack      (wb_ack),
    .i_wb_stall    (wb_stall),
    .i_wb_err      (wb_err),
    .i_wb_data     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] data_of(input logic [27:0] b);
    return {6'h2A, b[27:2]};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wishbone slave model: in-order acks with optional random delay and stall.
  initial begin : slave
    logic [25:0] pend[$];
    int          wait_cnt;
    wait_cnt = 0;
    s_ack    = 1'b0;
    s_stall  = 1'b0;
    s_data   = 32'h0;
    forever begin
      @(negedge clk);
      if (slv_en && wb_cyc && wb_stb && !wb_stall) begin
        pend.push_back(wb_addr);
      end
      @(posedge clk);
      #1;
      if (!slv_en) begin
        pend.delete();
        wait_cnt = 0;
        s_ack    = 1'b0;
        s_stall  = 1'b0;
      end else begin
        s_ack   = 1'b0;
        s_stall = slv_stall_rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else if (pend.size() > 0) begin
          s_ack    = 1'b1;
          s_data   = {6'h2A, pend.pop_front()};
          wait_cnt = $urandom_range(0, slv_maxdly);
        end
      end
    end
  end

  // Present one AR request until accepted; leaves arvalid high for back-to-back use.
  task automatic ar_send(input logic [27:0] a, input logic [1:0] resp);
    int   cnt;
    logic ok;
    cnt     = 0;
    ok      = 1'b0;
    arvalid = 1'b1;
    araddr  = a;
    #1;
    while (!arready && cnt < 200) begin
      tick();
      #1;
      cnt++;
    end
    ok = arready;
    if (!ok) begin
      check_val("ar_timeout", 64'(ok), 64'd1);
    end else begin
      exp_q.push_back('{data: data_of(a), resp: resp});
    end
    tick();
  endtask

  // Collect n R beats and compare against the expectation queue.
  task automatic rd_collect(input int n, input bit rnd);
    int   got;
    int   cyc;
    exp_t e;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 2000) begin
      rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          check_val("r_unexpected", 64'(rdata), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_val("rresp", 64'(rresp), 64'(e.resp));
          if (e.resp == 2'b00) begin
            check_val("rdata", 64'(rdata), 64'(e.data));
          end
        end
        got++;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    check_val("r_count", 64'(got), 64'(n));
  endtask

  initial begin : main
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    arvalid = 1'b0;
    araddr = 28'h0;
    rready = 1'b0;
    m_ack = 1'b0;
    m_stall = 1'b0;
    m_err = 1'b0;
    m_data = 32'h0;
    slv_en = 1'b0;
    slv_stall_rnd = 1'b0;
    slv_maxdly = 0;

    // reset values
    #3;
    check_val("rst_cyc", 64'(wb_cyc), 64'd0);
    check_val("rst_stb", 64'(wb_stb), 64'd0);
    check_val("rst_rvalid", 64'(rvalid), 64'd0);
    check_val("rst_arready", 64'(arready), 64'd1);
    check_val("wb_sel", 64'(wb_sel), 64'hF);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single read, ack one cycle after the strobe
    arvalid = 1'b1;
    araddr  = 28'h000_0010;
    #1;
    check_val("single_arready", 64'(arready), 64'd1);
    tick();
    arvalid = 1'b0;
    check_val("single_stb", 64'(wb_stb), 64'd1);
    check_val("single_addr", 64'(wb_addr), 64'h4);
    check_val("single_cyc", 64'(wb_cyc), 64'd1);
    check_val("single_rv_early", 64'(rvalid), 64'd0);
    tick();
    check_val("single_stb_drop", 64'(wb_stb), 64'd0);
    check_val("single_rv_early2", 64'(rvalid), 64'd0);
    m_ack  = 1'b1;
    m_data = 32'hDEAD_BEEF;
    tick();
    m_ack = 1'b0;
    check_val("single_rvalid", 64'(rvalid), 64'd1);
    check_val("single_rdata", 64'(rdata), 64'hDEAD_BEEF);
    check_val("single_rresp", 64'(rresp), 64'd0);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check_val("single_rv_done", 64'(rvalid), 64'd0);
    check_val("single_cyc_done", 64'(wb_cyc), 64'd0);

    // burst of 8 with rready low fills the response buffer
    slv_en = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      ar_send(28'h100 + 28'(4 * i), 2'b00);
    end
    araddr = 28'h200;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_val("burst_full_arready", 64'(arready), 64'd0);
      tick();
    end
    rready = 1'b1;
    #1;
    check_val("burst_rvalid", 64'(rvalid), 64'd1);
    check_val("burst_first_data", 64'(rdata), 64'(data_of(28'h100)));
    void'(exp_q.pop_front());
    tick();
    rready = 1'b0;
    #1;
    check_val("burst_reopen_arready", 64'(arready), 64'd1);
    tick();
    arvalid = 1'b0;
    exp_q.push_back('{data: data_of(28'h200), resp: 2'b00});
    #1;
    check_val("burst_refull_arready", 64'(arready), 64'd0);
    tick();
    rd_collect(8, 1'b0);

    // stall: strobe and address hold, arready low, one issue when stall drops
    slv_en  = 1'b0;
    m_stall = 1'b1;
    tick();
    ar_send(28'h300, 2'b00);
    araddr = 28'h304;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_val("stall_stb", 64'(wb_stb), 64'd1);
      check_val("stall_addr", 64'(wb_addr), 64'hC0);
      check_val("stall_arready", 64'(arready), 64'd0);
      tick();
    end
    slv_en  = 1'b1;
    m_stall = 1'b0;
    #1;
    check_val("unstall_arready", 64'(arready), 64'd1);
    tick();
    arvalid = 1'b0;
    exp_q.push_back('{data: data_of(28'h304), resp: 2'b00});
    check_val("unstall_next_addr", 64'(wb_addr), 64'hC1);
    check_val("unstall_next_stb", 64'(wb_stb), 64'd1);
    rd_collect(2, 1'b0);

    // error on the second of four reads: remaining reads get SLVERR
    slv_en = 1'b0;
    tick();
    ar_send(28'h400, 2'b00);
    ar_send(28'h404, 2'b10);
    ar_send(28'h408, 2'b10);
    ar_send(28'h40C, 2'b10);
    arvalid = 1'b0;
    m_ack  = 1'b1;
    m_data = data_of(28'h400);
    tick();
    m_ack = 1'b0;
    m_err = 1'b1;
    m_data = 32'h0;
    #1;
    check_val("err_cyc_during", 64'(wb_cyc), 64'd1);
    check_val("err_arready_during", 64'(arready), 64'd0);
    tick();
    m_err   = 1'b0;
    arvalid = 1'b1;
    araddr  = 28'h410;
    #1;
    check_val("err_cyc_after", 64'(wb_cyc), 64'd0);
    check_val("err_stb_after", 64'(wb_stb), 64'd0);
    for (int k = 0; k < 4; k++) begin
      check_val("err_drain_arready", 64'(arready), (k == 3) ? 64'd1 : 64'd0);
      if (k < 3) begin
        tick();
        #1;
      end
    end
    slv_en = 1'b1;
    tick();
    arvalid = 1'b0;
    exp_q.push_back('{data: data_of(28'h410), resp: 2'b00});
    rd_collect(5, 1'b0);

    // pointer wrap: 40 reads with random stall, ack delay and rready
    slv_stall_rnd = 1'b1;
    slv_maxdly    = 2;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          ar_send(28'h1000 + 28'(4 * i), 2'b00);
        end
        arvalid = 1'b0;
      end
      rd_collect(40, 1'b1);
    join
    slv_stall_rnd = 1'b0;
    slv_maxdly    = 0;
    tick();

    // async reset in the middle of a burst
    ar_send(28'h2000, 2'b00);
    ar_send(28'h2004, 2'b00);
    ar_send(28'h2008, 2'b00);
    arvalid = 1'b0;
    #1;
    check_val("prerst_cyc", 64'(wb_cyc), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_cyc", 64'(wb_cyc), 64'd0);
    check_val("midrst_stb", 64'(wb_stb), 64'd0);
    check_val("midrst_rvalid", 64'(rvalid), 64'd0);
    check_val("midrst_arready", 64'(arready), 64'd1);
    slv_en = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    slv_en = 1'b1;
    ar_send(28'h2010, 2'b00);
    arvalid = 1'b0;
    rd_collect(1, 1'b0);
    check_val("end_exp_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axil_rd2wbsp.md
# axil_rd2wbsp

Bridges an AXI-lite read channel pair (AR/R) to a pipelined Wishbone read master. It is the read-side companion to the AXI-lite write-to-Wishbone bridge. Paired with that block and an arbiter, it forms a full AXI-lite to Wishbone bridge. Requests are issued in order, up to 2^LGFIFO outstanding. Wishbone errors map to AXI SLVERR without losing response ordering.

## Interface
- C_AXI_DATA_WIDTH, 32, AXI/WB data width (DW); power of two, at least 8
- C_AXI_ADDR_WIDTH, 28, AXI byte-address width
- LGFIFO, 3, log2 of the maximum number of outstanding reads
- Derived: LSBS = log2(DW/8); AW = C_AXI_ADDR_WIDTH-LSBS (word-address width)

Ports:
- i_clk  in  1  single clock
- i_axi_reset_n  in  1  reset; asynchronous assert, active-low
- i_axi_arvalid  in  1  read-address valid
- o_axi_arready  out  1  read-address ready
- i_axi_araddr  in  C_AXI_ADDR_WIDTH  byte address
- i_axi_arprot  in  3  ignored
- o_axi_rvalid  out  1  read-data valid
- i_axi_rready  in  1  read-data ready
- o_axi_rdata  out  DW  read data
- o_axi_rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- o_wb_cyc, o_wb_stb  out  1  Wishbone cycle/strobe
- o_wb_addr  out  AW  word address, equal to araddr[C_AXI_ADDR_WIDTH-1:LSBS]
- o_wb_sel  out  DW/8  constant all-ones
- i_wb_ack, i_wb_stall, i_wb_err  in  1  Wishbone slave handshake
- i_wb_data  in  DW  Wishbone read data

## Operation
- Pointers: r_first counts accepted AR requests, r_mid counts Wishbone responses, r_last counts completed R handshakes. All are LGFIFO+1 bits and wrap modulo 2^(LGFIFO+1).
- Response memory: 2^LGFIFO entries of {data, err}, written at r_mid[LGFIFO-1:0] and read at r_last[LGFIFO-1:0].
- full = (r_first - r_last) == 2^LGFIFO.
- o_axi_arready is combinational and never depends on arvalid: (!o_wb_stb || !i_wb_stall) && !full && !err_state && !(o_wb_cyc && i_wb_err).
- AR accept: set o_wb_stb, load o_wb_addr, increment r_first.
- o_wb_stb clears when !i_wb_stall with no new accept, on error, or on reset. o_wb_addr holds while stb && stall.
- o_wb_cyc = (r_first != r_mid) && !err_state.
- Ack with cyc: write {i_wb_data, 0} at r_mid, increment r_mid.
- Err with cyc: write {x, 1} at r_mid, increment r_mid, set err_state.
- While err_state holds and r_mid != r_first: write {x, 1} and increment r_mid once per cycle. Each remaining issued read thus gets SLVERR.
- err_state clears on the cycle r_mid == r_first.
- Acks and errors are ignored while cyc is low.
- o_axi_rvalid = (r_mid != r_last). o_axi_rdata and o_axi_rresp are read from entry r_last; rresp = err ? 2'b10 : 2'b00.
- R handshake increments r_last.
- Simultaneous AR accept, WB ack and R handshake in one cycle: all three pointers advance independently.
- Reset: pointers 0, o_wb_stb 0, err_state 0. Hence o_wb_cyc=0, o_axi_rvalid=0, o_axi_arready=1. Memory contents are not reset. A reset mid-cycle abandons the bus cycle; slaves must tolerate this.

## Timing
- AR accept at edge N gives o_wb_stb high in cycle N+1.
- Back-to-back accepts keep stb high continuously, one request per non-stalled cycle.
- Ack in cycle K gives o_axi_rvalid in cycle K+1. Minimum AR-handshake-to-rvalid latency is 3 cycles.
- Error in cycle K: cyc and stb are low from K+1; remaining entries fill at one per cycle; arready is low until err_state clears.
- Full throughput: one read per cycle when stall=0, ack is one cycle later, and rready=1.
- rvalid, once high, holds with stable data until rready.

## Structure
- Shared package axil_wb_pkg: AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10. The write bridge uses the same constants.
- One sub-module: wb_rsp_fifo, a 2^LGFIFO x (DW+1) memory with synchronous write and asynchronous read. Pointer logic stays in the top.

## Test plan
- Single read: AR 0x0000_0010, ack next cycle with data 0xDEADBEEF -> o_wb_addr=0x4, rvalid 3 cycles after AR handshake, rdata=0xDEADBEEF, rresp=00.
- Burst of 8 reads with rready=0 and LGFIFO=3 -> 8 accepted, arready low on the 9th; after one R handshake, one more is accepted; data order is preserved.
- Stall: i_wb_stall high for 5 cycles -> stb and addr stable, arready low; one read issued when stall drops.
- Error: 4 reads issued, ack on #1, err on #2 -> rresp 00, 10, 10, 10; cyc low the cycle after err; new AR accepted only after r_mid == r_first.
- Pointer wrap: 40 sequential reads with random stall, rready and ack delay -> all data returned in order with no loss across the wrap.
- Async reset asserted mid-burst -> cyc, stb and rvalid low immediately; after release, a fresh read completes normally.
